// File: rtl/regfile_dump.sv
// regfile_dump: walks register indices 0..NUM_REGS-1 through one regfile read port and streams
// each byte on a valid/ready link. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rsNum,
    input  logic [DATA_WIDTH-1:0] rsData,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, FINISH, CKSUM} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] index;
    logic                  handshake;
    logic                  is_last_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc;
`endif

    assign handshake   = out_valid && out_ready;
    assign is_last_reg = (index == LAST_IDX);
    // The index register drives the read port directly, so rsNum is registered and 0 whenever idle.
    assign rsNum       = index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = FETCH;
            FETCH:  state_next = SEND;
            SEND: begin
                if (handshake) begin
                    if (out_last) state_next = FINISH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    else if (is_last_reg) state_next = CKSUM;
`endif
                    else state_next = FETCH;
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CKSUM:  state_next = SEND;
`endif
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            FETCH, SEND, CKSUM: busy = 1'b1;
            FINISH:             done = 1'b1;
            default:            ;
        endcase
    end

    // Datapath: capture in FETCH, hold through SEND, advance index on each accepted beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc   <= '0;
`endif
                    end
                end
                FETCH: begin
                    out_data  <= rsData;
                    out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    acc       <= acc ^ rsData;
`else
                    out_last  <= is_last_reg;
`endif
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (is_last_reg || out_last) begin
                            index <= '0;
                        end else begin
                            index <= index + IDX_ONE;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                CKSUM: begin
                    out_data  <= acc;
                    out_valid <= 1'b1;
                    out_last  <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural regfile plus a beat-list model of what each dump must emit.
module tb_regfile_dump;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 3;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int NB = NR + 1;
`else
    localparam int NB = NR;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_last;
    logic [AW-1:0] rsNum;
    logic [DW-1:0] rsData;
    logic [DW-1:0] out_data;
    logic [DW-1:0] mem [NR];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign rsData = mem[rsNum];

    regfile_dump #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rsNum(rsNum), .rsData(rsData), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One full dump. Expected beats are the register contents at the time each register is
    // fetched: a write while beat k is on the link reaches the output only for registers above k.
    task automatic dump(input string name, input int stall_beat, input int stall_len,
                        input int restart_beat, input int write_beat, input int write_idx,
                        input logic [DW-1:0] write_val, input bit rand_ready);
        logic [DW-1:0] exp [NR];
        logic [DW-1:0] want;
        logic [DW-1:0] held = '0;
        int  beats = 0, cyc = 0, busy_cyc = 0, hs_cyc = -1, done_cyc = -1, first_vld = -1;
        int  stall_left = stall_len;
        bit  holding = 1'b0, restarted = 1'b0, written = 1'b0;
        for (int i = 0; i < NR; i++) exp[i] = mem[i];
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, ":fetch_vld"}, out_valid, 0);
        while (cyc < 400) begin
            if (done) begin
                done_cyc = cyc;
                check({name, ":done_busy"}, busy, 0);
                break;
            end
            if (busy) busy_cyc++;
            if (out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (holding) check({name, ":hold"}, out_data, held);
                if (beats == restart_beat && !restarted) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end
                if (beats == write_beat && !written) begin
                    mem[write_idx] = write_val;
                    if (write_idx > beats) exp[write_idx] = write_val;
                    written = 1'b1;
                end
                if (beats == stall_beat && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    if (beats < NR) begin
                        want = exp[beats];
                        check({name, ":rsnum"}, rsNum, beats);
                    end else begin
                        want = '0;
                        for (int i = 0; i < NR; i++) want ^= exp[i];
                    end
                    check({name, ":data"}, out_data, want);
                    check({name, ":last"}, out_last, (beats == NB - 1));
                    beats++;
                    hs_cyc  = cyc;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = out_data;
                end
            end else begin
                if (holding) begin
                    check({name, ":vld_drop"}, out_valid, 1);
                    holding = 1'b0;
                end
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
        end
        check({name, ":beats"}, beats, NB);
        check({name, ":done_lat"}, done_cyc, hs_cyc + 1);
        if (!rand_ready) begin
            check({name, ":busy_cyc"}, busy_cyc, 2 * NB + ((stall_beat >= 0) ? stall_len : 0));
            check({name, ":first_vld"}, first_vld, 1);
        end
        @(posedge clock); #1;
        check({name, ":done_pulse"}, done, 0);
        check({name, ":idle_busy"}, busy, 0);
        check({name, ":idle_rsnum"}, rsNum, 0);
        @(posedge clock); #1;
        check({name, ":no_requeue"}, busy, 0);
        check({name, ":idle_vld"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < NR; i++) mem[i] = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rsnum", rsNum, 0);
        check("rst_data", out_data, 0);
        check("rst_vld", out_valid, 0);
        check("rst_last", out_last, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < NR; i++) mem[i] = 8'(8'h10 + i);
        dump("basic", -1, 0, -1, -1, 0, 8'h00, 1'b0);

        for (int i = 0; i < NR; i++) mem[i] = 8'(8'hA0 + i);
        dump("bp", 3, 5, -1, -1, 0, 8'h00, 1'b0);

        dump("restart", -1, 0, 2, -1, 0, 8'h00, 1'b0);

        for (int i = 0; i < NR; i++) mem[i] = 8'(8'h20 + i);
        dump("wr5", -1, 0, -1, 1, 5, 8'hEE, 1'b0);
        for (int i = 0; i < NR; i++) mem[i] = 8'(8'h20 + i);
        dump("wr0", -1, 0, -1, 1, 0, 8'h55, 1'b0);

        for (int i = 0; i < NR; i++) mem[i] = 8'(1 << i);
        dump("xor", -1, 0, -1, -1, 0, 8'h00, 1'b0);

        // Reset asserted between edges while beat 4 waits on the link
        for (int i = 0; i < NR; i++) mem[i] = 8'(8'h30 + i);
        seen = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (seen == 4) begin
                    out_ready = 1'b0;
                    break;
                end
                seen++;
            end
            @(posedge clock); #1;
        end
        check("mid_reach", seen, 4);
        check("mid_vld_pre", out_valid, 1);
        #3 reset = 1'b1;
        #1;
        check("mid_vld", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_rsnum", rsNum, 0);
        check("mid_done", done, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            @(posedge clock); #1;
        end
        dump("after_rst", -1, 0, -1, -1, 0, 8'h00, 1'b0);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NR; i++) mem[i] = 8'($urandom);
            dump("rand", -1, 0, int'($urandom_range(0, NB)), int'($urandom_range(0, NB - 1)),
                 int'($urandom_range(0, NR - 1)), 8'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
